// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and the write-port priority resolver
// used by both the storage update and the read bypass path.
package regfile_pkg;

    localparam int DEF_W     = 64;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NR    = 3;
    localparam int DEF_NW    = 2;

    // Widest write-port count and address the resolver is built for.
    localparam int NW_MAX = 2;
    localparam int AW_MAX = 16;
    localparam int WP_W   = 1;

    typedef struct packed {
        logic            hit;
        logic [WP_W-1:0] port;
    } wsel_t;

    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Ascending scan: a later (higher-index) port overrides an earlier match.
    function automatic wsel_t wsel(input logic [NW_MAX-1:0]        en,
                                   input logic [NW_MAX*AW_MAX-1:0] addrs,
                                   input logic [AW_MAX-1:0]        addr);
        wsel_t r;
        r = '0;
        for (int j = 0; j < NW_MAX; j++) begin
            if (en[j] && (addrs[j*AW_MAX +: AW_MAX] == addr)) begin
                r.hit  = 1'b1;
                r.port = WP_W'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bundle of the register file: read ports,
// write ports, scoreboard set and the busy vector.
interface regfile_mp_if import regfile_pkg::*; #(
    parameter int W     = DEF_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NR    = DEF_NR,
    parameter int NW    = DEF_NW
);
    localparam int AW = addr_w(DEPTH);

    logic [NR*AW-1:0] rd_addr;
    logic [NR*W-1:0]  rd_data;
    logic [NR-1:0]    rd_busy;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*W-1:0]  wr_data;
    logic             sb_set;
    logic [AW-1:0]    sb_id;
    logic [DEPTH-1:0] busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_id,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_id,
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One read port: storage mux, optional same-cycle write forwarding and the
// registered data/busy outputs.
module regfile_rd_port import regfile_pkg::*; #(
    parameter int W      = DEF_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NW     = DEF_NW,
    parameter int BYPASS = 1,
    parameter int AW     = addr_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DEPTH*W-1:0]       regs,
    input  logic [DEPTH-1:0]         busy_cur,
    input  logic [DEPTH-1:0]         busy_next,
    input  logic [AW-1:0]            addr,
    input  logic [NW_MAX-1:0]        wr_en_x,
    input  logic [NW_MAX*AW_MAX-1:0] wr_addr_x,
    input  logic [NW*W-1:0]          wr_data,
    output logic [W-1:0]             data,
    output logic                     busy
);

    wsel_t          sel;
    logic [W-1:0]   data_next;
    logic           busy_next_sel;
    logic [W-1:0]   data_reg;
    logic           busy_reg;

    always_comb begin
        sel           = wsel(wr_en_x, wr_addr_x, AW_MAX'(addr));
        data_next     = regs[int'(addr)*W +: W];
        busy_next_sel = busy_cur[addr];
        // Forwarding also exposes the post-update scoreboard bit.
        if (BYPASS != 0) begin
            busy_next_sel = busy_next[addr];
            if (sel.hit) begin
                data_next = wr_data[int'(sel.port)*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg <= '0;
            busy_reg <= 1'b0;
        end else begin
            data_reg <= data_next;
            busy_reg <= busy_next_sel;
        end
    end

    assign data = data_reg;
    assign busy = busy_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with prioritised writes, read bypass and a
// per-register busy scoreboard for RAW hazard detection.
module regfile_mp import regfile_pkg::*; #(
    parameter int W      = DEF_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NR     = DEF_NR,
    parameter int NW     = DEF_NW,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    localparam int AW = addr_w(DEPTH);

    logic [DEPTH*W-1:0]       mem_reg;
    logic [DEPTH*W-1:0]       mem_next;
    logic [DEPTH-1:0]         busy_reg;
    logic [DEPTH-1:0]         busy_next;
    logic [NW_MAX-1:0]        wr_en_x;
    logic [NW_MAX*AW_MAX-1:0] wr_addr_x;

    // Widen write ports to the resolver's fixed shape; absent ports never hit.
    generate
        for (genvar gi = 0; gi < NW_MAX; gi++) begin : g_wx
            if (gi < NW) begin : g_used
                assign wr_en_x[gi]                     = bus.wr_en[gi];
                assign wr_addr_x[gi*AW_MAX +: AW_MAX]  = AW_MAX'(bus.wr_addr[gi*AW +: AW]);
            end else begin : g_unused
                assign wr_en_x[gi]                     = 1'b0;
                assign wr_addr_x[gi*AW_MAX +: AW_MAX]  = '0;
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            wsel_t sel;
            logic  set_hit;

            assign sel     = wsel(wr_en_x, wr_addr_x, AW_MAX'(gi));
            assign set_hit = bus.sb_set && (bus.sb_id == AW'(gi));

            assign mem_next[gi*W +: W] = sel.hit ? bus.wr_data[int'(sel.port)*W +: W]
                                                 : mem_reg[gi*W +: W];
            // A newly issued producer outranks the completing one.
            assign busy_next[gi] = set_hit | (busy_reg[gi] & ~sel.hit);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_reg  <= '0;
            busy_reg <= '0;
        end else begin
            mem_reg  <= mem_next;
            busy_reg <= busy_next;
        end
    end

    assign bus.busy_vec = busy_reg;

    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_rd
            regfile_rd_port #(
                .W      (W),
                .DEPTH  (DEPTH),
                .NW     (NW),
                .BYPASS (BYPASS),
                .AW     (AW)
            ) u_rd (
                .clk       (clk),
                .rst       (rst),
                .regs      (mem_reg),
                .busy_cur  (busy_reg),
                .busy_next (busy_next),
                .addr      (bus.rd_addr[gi*AW +: AW]),
                .wr_en_x   (wr_en_x),
                .wr_addr_x (wr_addr_x),
                .wr_data   (bus.wr_data),
                .data      (bus.rd_data[gi*W +: W]),
                .busy      (bus.rd_busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Drives a bypassing and a non-bypassing register file with identical
// stimulus and compares both against an array-based model.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int W     = 64;
    localparam int DEPTH = 32;
    localparam int NR    = 3;
    localparam int NW    = 2;
    localparam int AW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR*AW-1:0] rd_addr = '0;
    logic [NW-1:0]    wr_en   = '0;
    logic [NW*AW-1:0] wr_addr = '0;
    logic [NW*W-1:0]  wr_data = '0;
    logic             sb_set  = 1'b0;
    logic [AW-1:0]    sb_id   = '0;

    regfile_mp_if #(.W(W), .DEPTH(DEPTH), .NR(NR), .NW(NW)) bus_b ();
    regfile_mp_if #(.W(W), .DEPTH(DEPTH), .NR(NR), .NW(NW)) bus_n ();

    assign bus_b.rd_addr = rd_addr;
    assign bus_b.wr_en   = wr_en;
    assign bus_b.wr_addr = wr_addr;
    assign bus_b.wr_data = wr_data;
    assign bus_b.sb_set  = sb_set;
    assign bus_b.sb_id   = sb_id;
    assign bus_n.rd_addr = rd_addr;
    assign bus_n.wr_en   = wr_en;
    assign bus_n.wr_addr = wr_addr;
    assign bus_n.wr_data = wr_data;
    assign bus_n.sb_set  = sb_set;
    assign bus_n.sb_id   = sb_id;

    regfile_mp #(.W(W), .DEPTH(DEPTH), .NR(NR), .NW(NW), .BYPASS(1)) u_dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );
    regfile_mp #(.W(W), .DEPTH(DEPTH), .NR(NR), .NW(NW), .BYPASS(0)) u_dut_n (
        .clk (clk), .rst (rst), .bus (bus_n)
    );

    // Model state; index 0 = bypassing file, 1 = non-bypassing file.
    logic [W-1:0] mem_m [2][DEPTH];
    logic         busy_m [2][DEPTH];
    logic [W-1:0] rdd_m [2][NR];
    logic         rdb_m [2][NR];

    int pass_cnt  = 0;
    int total_cnt = 0;

    function automatic logic [W-1:0] obs_data(input int b, input int k);
        return (b == 0) ? bus_b.rd_data[k*W +: W] : bus_n.rd_data[k*W +: W];
    endfunction

    function automatic logic obs_busy(input int b, input int k);
        return (b == 0) ? bus_b.rd_busy[k] : bus_n.rd_busy[k];
    endfunction

    function automatic logic [DEPTH-1:0] obs_vec(input int b);
        return (b == 0) ? bus_b.busy_vec : bus_n.busy_vec;
    endfunction

    function automatic logic [DEPTH-1:0] model_vec(input int b);
        logic [DEPTH-1:0] v;
        for (int r = 0; r < DEPTH; r++) v[r] = busy_m[b][r];
        return v;
    endfunction

    task automatic clear_inputs();
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        sb_set = 1'b0; sb_id = '0;
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int j, input int a, input logic [W-1:0] d);
        wr_en[j] = 1'b1;
        wr_addr[j*AW +: AW] = AW'(a);
        wr_data[j*W +: W]   = d;
    endtask

    // Apply one clock edge to the model: writes in port order, then sb_set,
    // reads see the new state only on the bypassing file.
    task automatic step();
        logic [W-1:0] nm  [2][DEPTH];
        logic         nb  [2][DEPTH];
        logic [W-1:0] nrd [2][NR];
        logic         nrb [2][NR];
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < DEPTH; r++) begin
                nm[b][r] = mem_m[b][r];
                nb[b][r] = busy_m[b][r];
            end
            for (int j = 0; j < NW; j++) begin
                if (wr_en[j]) begin
                    nm[b][wr_addr[j*AW +: AW]] = wr_data[j*W +: W];
                    nb[b][wr_addr[j*AW +: AW]] = 1'b0;
                end
            end
            if (sb_set) nb[b][sb_id] = 1'b1;
            for (int k = 0; k < NR; k++) begin
                nrd[b][k] = (b == 0) ? nm[b][rd_addr[k*AW +: AW]] : mem_m[b][rd_addr[k*AW +: AW]];
                nrb[b][k] = (b == 0) ? nb[b][rd_addr[k*AW +: AW]] : busy_m[b][rd_addr[k*AW +: AW]];
            end
            if (rst) begin
                for (int r = 0; r < DEPTH; r++) begin nm[b][r] = '0; nb[b][r] = 1'b0; end
                for (int k = 0; k < NR; k++) begin nrd[b][k] = '0; nrb[b][k] = 1'b0; end
            end
        end
        @(posedge clk);
        #1;
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_m[b][r]  = nm[b][r];
                busy_m[b][r] = nb[b][r];
            end
            for (int k = 0; k < NR; k++) begin
                rdd_m[b][k] = nrd[b][k];
                rdb_m[b][k] = nrb[b][k];
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear_inputs();
        step(); step();
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < NR; k++) begin
                total_cnt++;
                if (obs_data(b, k) !== '0 || obs_busy(b, k) !== 1'b0)
                    $display("FAIL reset_out dut%0d port%0d: got data=%h busy=%b, want 0/0", b, k, obs_data(b, k), obs_busy(b, k));
                else pass_cnt++;
            end
            total_cnt++;
            if (obs_vec(b) !== '0) $display("FAIL reset_busy_vec dut%0d: got %h, want 0", b, obs_vec(b));
            else pass_cnt++;
        end
        rst = 1'b0;
        set_wr(0, 5, 64'hDEAD);
        step();
        // Reset with a write and an sb_set pending: both must be dropped.
        rst = 1'b1; clear_inputs();
        set_wr(1, 6, 64'hBEEF); sb_set = 1'b1; sb_id = AW'(6);
        step();
        rst = 1'b0; clear_inputs();
        set_rd(0, 5); set_rd(1, 6);
        step();
        for (int b = 0; b < 2; b++) begin
            total_cnt++;
            if (obs_data(b, 0) !== '0) $display("FAIL reset_reg5 dut%0d: got %h, want 0", b, obs_data(b, 0));
            else pass_cnt++;
            total_cnt++;
            if (obs_data(b, 1) !== '0 || obs_vec(b) !== '0)
                $display("FAIL reset_drop dut%0d: got reg6=%h vec=%h, want 0/0", b, obs_data(b, 1), obs_vec(b));
            else pass_cnt++;
        end
        $display("reset: done");
    endtask

    task automatic test_basic();
        clear_inputs();
        set_wr(0, 3, 64'h1234);
        step();
        clear_inputs();
        for (int k = 0; k < NR; k++) set_rd(k, 3);
        step();
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < NR; k++) begin
                total_cnt++;
                if (obs_data(b, k) !== 64'h1234)
                    $display("FAIL basic_read dut%0d port%0d: got %h, want 1234", b, k, obs_data(b, k));
                else pass_cnt++;
            end
        end
        $display("basic: reg3 read on %0d ports", NR);
    endtask

    task automatic test_bypass();
        clear_inputs();
        set_wr(0, 7, 64'hAA);
        for (int k = 0; k < NR; k++) set_rd(k, 7);
        step();
        for (int k = 0; k < NR; k++) begin
            total_cnt++;
            if (obs_data(0, k) !== 64'hAA) $display("FAIL bypass_on port%0d: got %h, want aa", k, obs_data(0, k));
            else pass_cnt++;
            total_cnt++;
            if (obs_data(1, k) !== 64'h0) $display("FAIL bypass_off port%0d: got %h, want 0", k, obs_data(1, k));
            else pass_cnt++;
        end
        $display("bypass: reg7 same-cycle read");
    endtask

    task automatic test_conflict();
        clear_inputs();
        set_wr(0, 9, 64'h11); set_wr(1, 9, 64'h22); set_rd(0, 9);
        step();
        total_cnt++;
        if (obs_data(0, 0) !== 64'h22) $display("FAIL conflict_bypass: got %h, want 22", obs_data(0, 0));
        else pass_cnt++;
        clear_inputs();
        for (int k = 0; k < NR; k++) set_rd(k, 9);
        step();
        for (int b = 0; b < 2; b++) begin
            total_cnt++;
            if (obs_data(b, NR-1) !== 64'h22) $display("FAIL conflict_store dut%0d: got %h, want 22", b, obs_data(b, NR-1));
            else pass_cnt++;
        end
        $display("conflict: reg9 port1 wins");
    endtask

    task automatic test_scoreboard();
        clear_inputs(); sb_set = 1'b1; sb_id = AW'(4);
        step();
        clear_inputs(); set_rd(0, 4);
        step();
        for (int b = 0; b < 2; b++) begin
            total_cnt++;
            if (obs_busy(b, 0) !== 1'b1) $display("FAIL sb_rd_busy dut%0d: got %b, want 1", b, obs_busy(b, 0));
            else pass_cnt++;
        end
        clear_inputs(); set_wr(0, 4, 64'h55);
        step();
        for (int b = 0; b < 2; b++) begin
            total_cnt++;
            if (obs_vec(b)[4] !== 1'b0) $display("FAIL sb_clear dut%0d: got %b, want 0", b, obs_vec(b)[4]);
            else pass_cnt++;
        end
        clear_inputs(); set_wr(1, 4, 64'h66); sb_set = 1'b1; sb_id = AW'(4); set_rd(1, 4);
        step();
        for (int b = 0; b < 2; b++) begin
            total_cnt++;
            if (obs_vec(b)[4] !== 1'b1) $display("FAIL sb_set_wins dut%0d: got %b, want 1", b, obs_vec(b)[4]);
            else pass_cnt++;
            total_cnt++;
            if (obs_busy(b, 1) !== rdb_m[b][1]) $display("FAIL sb_rd_post dut%0d: got %b, want %b", b, obs_busy(b, 1), rdb_m[b][1]);
            else pass_cnt++;
        end
        $display("scoreboard: set/read/clear/set-wins");
    endtask

    task automatic test_random();
        int errs;
        for (int n = 0; n < 300; n++) begin
            clear_inputs();
            rst = ($urandom_range(0, 31) == 0);
            for (int j = 0; j < NW; j++)
                if ($urandom_range(0, 1) == 1)
                    set_wr(j, $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH-1), {$urandom, $urandom});
            for (int k = 0; k < NR; k++) set_rd(k, $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH-1));
            sb_set = ($urandom_range(0, 2) == 0);
            sb_id  = AW'($urandom_range(0, 7));
            step();
            errs = 0;
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < NR; k++) begin
                    total_cnt++;
                    if (obs_data(b, k) !== rdd_m[b][k] || obs_busy(b, k) !== rdb_m[b][k]) begin
                        errs++;
                        $display("FAIL rand_rd cyc%0d dut%0d port%0d: got %h/%b, want %h/%b",
                                 n, b, k, obs_data(b, k), obs_busy(b, k), rdd_m[b][k], rdb_m[b][k]);
                    end else pass_cnt++;
                end
                total_cnt++;
                if (obs_vec(b) !== model_vec(b)) begin
                    errs++;
                    $display("FAIL rand_vec cyc%0d dut%0d: got %h, want %h", n, b, obs_vec(b), model_vec(b));
                end else pass_cnt++;
            end
            if (n % 50 == 0) $display("random: cycle %0d rst=%b errors=%0d", n, rst, errs);
        end
        rst = 1'b0;
    endtask

    task automatic test_mid_reset();
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            clear_inputs();
            set_wr(0, n + 10, {$urandom, $urandom}); set_wr(1, n + 20, {$urandom, $urandom});
            sb_set = 1'b1; sb_id = AW'(n + 1);
            for (int k = 0; k < NR; k++) set_rd(k, n + 10);
            step();
        end
        rst = 1'b1;
        set_wr(0, 12, 64'hF00D); sb_set = 1'b1; sb_id = AW'(12);
        step();
        for (int b = 0; b < 2; b++) begin
            total_cnt++;
            if (obs_vec(b) !== '0) $display("FAIL midrst_vec dut%0d: got %h, want 0", b, obs_vec(b));
            else pass_cnt++;
            for (int k = 0; k < NR; k++) begin
                total_cnt++;
                if (obs_data(b, k) !== '0 || obs_busy(b, k) !== 1'b0)
                    $display("FAIL midrst_out dut%0d port%0d: got %h/%b, want 0/0", b, k, obs_data(b, k), obs_busy(b, k));
                else pass_cnt++;
            end
        end
        rst = 1'b0; clear_inputs();
        for (int base = 0; base < DEPTH; base += NR) begin
            for (int k = 0; k < NR; k++) set_rd(k, (base + k) % DEPTH);
            step();
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < NR; k++) begin
                    total_cnt++;
                    if (obs_data(b, k) !== '0)
                        $display("FAIL midrst_reg dut%0d reg%0d: got %h, want 0", b, (base + k) % DEPTH, obs_data(b, k));
                    else pass_cnt++;
                end
            end
        end
        $display("mid_reset: state cleared");
    endtask

    initial begin
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < DEPTH; r++) begin mem_m[b][r] = '0; busy_m[b][r] = 1'b0; end
            for (int k = 0; k < NR; k++) begin rdd_m[b][k] = '0; rdb_m[b][k] = 1'b0; end
        end
        test_reset();
        test_basic();
        test_bypass();
        test_conflict();
        test_scoreboard();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the uPOWER datapath. It is the successor to the fixed 2-read/1-write file and adds:
- configurable width, depth and port counts;
- write-to-read bypass;
- deterministic write-port priority;
- a per-register scoreboard (busy bits) that the decode stage uses for RAW hazard detection.

It sits between decode (read/issue) and writeback (write/clear).

## Interface
Parameters:
- W, 64: register width in bits.
- DEPTH, 32: number of registers. Must be ≥2 and a power of two.
- NR, 3: read ports. Range 1..4.
- NW, 2: write ports. Range 1..2.
- BYPASS, 1: 1 = same-cycle write data is forwarded to reads; 0 = reads see the pre-write value.
- AW, $clog2(DEPTH): address width. Derived; not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  in  NR*AW  read addresses; port k is bits [k*AW +: AW].
- rd_data  out  NR*W  registered read data; port k is bits [k*W +: W].
- rd_busy  out  NR  registered busy flag of the addressed register.
- wr_en  in  NW  write enables, one per port.
- wr_addr  in  NW*AW  write addresses.
- wr_data  in  NW*W  write data.
- sb_set  in  1  mark register sb_id busy; an in-flight producer has been issued.
- sb_id  in  AW  register to mark busy.
- busy_vec  out  DEPTH  current scoreboard state, unregistered view of the state flops.

## Operation
- Storage: DEPTH × W flops.
- Write:
  - On the clk edge with rst=0 and wr_en[j]=1: reg[wr_addr[j]] <= wr_data[j].
  - If two ports write the same address in one cycle, the higher port index wins.
- Read:
  - Every cycle with rst=0: rd_data[k] <= value of reg[rd_addr[k]] and rd_busy[k] <= busy of rd_addr[k].
  - Reads are never gated; there is no read enable.
- Bypass (BYPASS=1):
  - If any wr_en[j] targets rd_addr[k] in the same cycle, rd_data[k] captures the winning wr_data, using the same priority as the write.
  - The rd_busy[k] capture reflects the post-update busy value.
- Bypass (BYPASS=0): rd_data[k] captures the old stored value.
- Scoreboard:
  - Any write to register r clears busy[r].
  - sb_set sets busy[sb_id].
  - If set and clear hit the same register in one cycle, set wins, because a newer producer has been issued.
  - Setting an already-busy register is legal; it stays 1.
- Reset:
  - While rst=1, all registers, busy bits, rd_data and rd_busy go to 0 on each edge.
  - Writes and sb_set are ignored while rst=1.
  - Asserting rst mid-operation discards all pending state on that edge.
- Out-of-range addresses cannot occur, since DEPTH is a power of two.

## Timing
- Read latency: 1 cycle. Address presented in cycle n gives data valid after edge n+1.
- Write visibility:
  - BYPASS=1: the written value is visible to a read issued in the same cycle, at n+1.
  - BYPASS=0: it is visible to reads issued from cycle n+1, at n+2.
- Scoreboard latency:
  - busy_vec changes on the edge after sb_set or a write.
  - rd_busy follows the read-capture rule above.
- Reset values: rd_data=0, rd_busy=0, busy_vec=0, every register=0. These hold from the first edge with rst=1.
- There are no stalls or handshakes; every port is serviced every cycle.

## Structure
- Package regfile_pkg holds:
  - default W, DEPTH, NR, NW;
  - a function addr_w(depth) returning the address width;
  - a function wsel(...) that resolves the winning write port for an address. It is shared by the storage-write and bypass logic so both use the same priority.
- Sub-module regfile_rd_port holds the per-port read mux, bypass compare and output register. It is instantiated NR times in a generate loop.
- The top level holds storage, write priority and the scoreboard.

## Test plan
- Reset:
  - Stimulus: write reg5=0xDEAD, then assert rst for 1 cycle, then read reg5.
  - Required response: rd_data=0, busy_vec=0, and writes presented during rst are not stored.
- Basic read/write:
  - Stimulus: write reg3=0x1234 via port 0, then read reg3 on all NR ports the next cycle.
  - Required response: every port shows 0x1234 one cycle later.
- Bypass:
  - Stimulus: with BYPASS=1, write reg7=0xAA and read reg7 in the same cycle.
  - Required response: rd_data=0xAA at n+1. Repeat with BYPASS=0 and require the old value 0.
- Write conflict:
  - Stimulus: in one cycle, port0 writes reg9=0x11 and port1 writes reg9=0x22.
  - Required response: the stored value and the bypassed read are both 0x22.
- Scoreboard:
  - Stimulus: sb_set reg4; next cycle read reg4; then write reg4.
  - Required response: rd_busy=1 after the read, and busy_vec[4]=0 after the write edge.
  - Stimulus: sb_set reg4 and a write to reg4 in the same cycle.
  - Required response: busy_vec[4]=1.
- Mid-operation reset:
  - Stimulus: issue several sb_set and writes, then assert rst while they are in flight.
  - Required response: all busy bits, registers and outputs are 0 on that edge.
